// File: rtl/fft_frame_sequencer.sv
// Frame sequencer for an in-place radix-2 FFT core: loads N samples, waits for the core's done
// signal, then streams all N bins out through a 2-entry skid FIFO with full backpressure.
module fft_frame_sequencer #(
  parameter int unsigned N      = 512,
  parameter int unsigned L_max  = 9,
  parameter int unsigned W      = 24,
  parameter bit          BITREV = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W-1:0]     in_re,
  input  logic signed [W-1:0]     in_im,
  output logic                    fft_initial_en,
  output logic signed [W-1:0]     fft_datain_re,
  output logic signed [W-1:0]     fft_datain_im,
  input  logic                    fft_finish,
  output logic        [L_max-1:0] fft_read_addr,
  input  logic signed [W-1:0]     fft_dataout_re,
  input  logic signed [W-1:0]     fft_dataout_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [W-1:0]     out_re,
  output logic signed [W-1:0]     out_im,
  output logic        [L_max-1:0] out_index,
  output logic                    out_last,
  output logic                    busy
);

  localparam int unsigned       CW      = L_max + 1;
  localparam logic [CW-1:0]     NCnt    = CW'(N);
  localparam logic [L_max-1:0]  LastIdx = L_max'(N - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StDrain} state_e;

  typedef struct packed {
    logic [W-1:0]     re;
    logic [W-1:0]     im;
    logic [L_max-1:0] idx;
  } entry_t;

  function automatic logic [L_max-1:0] bitrev(input logic [L_max-1:0] a);
    logic [L_max-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < L_max; i++) begin
      r[i] = a[L_max-1-i];
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [CW-1:0]    load_cnt_q, load_cnt_d;
  logic [CW-1:0]    ia_q, ia_d;
  logic             inflight_q;
  logic [L_max-1:0] inflight_idx_q;
  logic [1:0]       fifo_cnt_q, fifo_cnt_d;
  entry_t           head_q, head_d, tail_q, tail_d;

  logic             accept, pop, push, issue;
  logic [L_max-1:0] addr_idx;
  logic [1:0]       slot;
  entry_t           new_entry;

  assign in_ready  = (state_q == StIdle) || ((state_q == StLoad) && (load_cnt_q != NCnt));
  assign busy      = (state_q != StIdle);
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign out_re    = head_q.re;
  assign out_im    = head_q.im;
  assign out_index = head_q.idx;
  assign out_last  = out_valid && (head_q.idx == LastIdx);

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  assign push   = inflight_q;

  // Occupancy after this cycle's pop, counting the read already in flight, must leave room.
  assign issue = (state_q == StDrain) && (ia_q != NCnt) &&
                 (({1'b0, fifo_cnt_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

  // Once all bins are issued the address freezes on the last one.
  assign addr_idx      = (ia_q == NCnt) ? LastIdx : ia_q[L_max-1:0];
  assign fft_read_addr = BITREV ? bitrev(addr_idx) : addr_idx;

  assign new_entry = '{re: fft_dataout_re, im: fft_dataout_im, idx: inflight_idx_q};

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    ia_d       = ia_q;
    unique case (state_q)
      StIdle, StLoad: begin
        if (accept) begin
          load_cnt_d = load_cnt_q + CW'(1);
          state_d    = (load_cnt_d == NCnt) ? StWait : StLoad;
        end
      end
      StWait: begin
        if (fft_finish) state_d = StDrain;
      end
      StDrain: begin
        if (issue) ia_d = ia_q + CW'(1);
        if (pop && out_last) begin
          state_d    = StIdle;
          ia_d       = '0;
          load_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Shift FIFO: a pop moves the tail forward, a push lands behind whatever remains.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    slot       = fifo_cnt_q - {1'b0, pop};
    if (pop) head_d = tail_q;
    if (push) begin
      if (slot == 2'd0) head_d = new_entry;
      else              tail_d = new_entry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      load_cnt_q     <= '0;
      ia_q           <= '0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
      fifo_cnt_q     <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      fft_initial_en <= 1'b0;
      fft_datain_re  <= '0;
      fft_datain_im  <= '0;
    end else begin
      state_q        <= state_d;
      load_cnt_q     <= load_cnt_d;
      ia_q           <= ia_d;
      inflight_q     <= issue;
      if (issue) inflight_idx_q <= ia_q[L_max-1:0];
      fifo_cnt_q     <= fifo_cnt_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      fft_initial_en <= accept;
      if (accept) begin
        fft_datain_re <= in_re;
        fft_datain_im <= in_im;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer (N=512, BITREV=1) with a 1-cycle-latency core model.
module tb_fft_frame_sequencer;

  localparam int N = 512;
  localparam int L = 9;
  localparam int W = 24;

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic [L-1:0] idx;
    logic         last;
  } res_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] in_re = '0;
  logic signed [W-1:0] in_im = '0;
  logic                fft_initial_en;
  logic signed [W-1:0] fft_datain_re, fft_datain_im;
  logic                fft_finish = 1'b0;
  logic        [L-1:0] fft_read_addr;
  logic signed [W-1:0] core_re = '0;
  logic signed [W-1:0] core_im = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic signed [W-1:0] out_re, out_im;
  logic        [L-1:0] out_index;
  logic                out_last;
  logic                busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobes = 0;
  int pops = 0;
  int first_pop = 0;
  int last_pop = 0;
  bit rdy_rand = 1'b1;

  logic [2*W-1:0] load_q[$];
  res_t           out_q[$];

  fft_frame_sequencer #(.N(N), .L_max(L), .W(W), .BITREV(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .fft_initial_en(fft_initial_en), .fft_datain_re(fft_datain_re),
    .fft_datain_im(fft_datain_im), .fft_finish(fft_finish), .fft_read_addr(fft_read_addr),
    .fft_dataout_re(core_re), .fft_dataout_im(core_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_index(out_index), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Core model: bin at address a holds re=a, im=~a, returned one cycle after the address.
  always @(posedge clk) begin
    core_re <= {{(W-L){1'b0}}, fft_read_addr};
    core_im <= ~{{(W-L){1'b0}}, fft_read_addr};
  end

  initial forever @(posedge clk) cyc++;

  initial forever begin
    @(posedge clk);
    #1 out_ready = rdy_rand ? 1'($urandom % 2) : 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [L-1:0] brev(input logic [L-1:0] a);
    logic [L-1:0] r;
    for (int i = 0; i < L; i++) r[L-1-i] = a[i];
    return r;
  endfunction

  // Monitor: strobe scoreboard, result scoreboard, and hold-while-stalled check.
  initial begin
    bit   stall_prev;
    res_t prev, got, e;
    stall_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_prev = 1'b0;
      end else begin
        if (fft_initial_en === 1'b1) begin
          strobes++;
          if (load_q.size() == 0) chk("strobe_extra", 64'(strobes), 64'(0));
          else chk("strobe_data", 64'({fft_datain_re, fft_datain_im}), 64'(load_q.pop_front()));
        end
        got = '{re: out_re, im: out_im, idx: out_index, last: out_last};
        if (stall_prev) begin
          chk("stall_valid", 64'(out_valid), 64'(1));
          chk("stall_hold", 64'(got), 64'(prev));
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          if (out_q.size() == 0) begin
            chk("result_extra", 64'(got), 64'(0));
          end else begin
            e = out_q.pop_front();
            chk("result", 64'(got), 64'(e));
          end
          if (pops == 0) first_pop = cyc;
          last_pop = cyc;
          pops++;
        end
        stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0);
        prev = got;
      end
    end
  end

  task automatic load_frame(input bit gapped, input bit fin_last, input bit fin_rand);
    int i = 0;
    int guard = 0;
    strobes = 0;
    while (i < N && guard < 8 * N) begin
      @(posedge clk);
      #1;
      in_valid   = gapped ? 1'($urandom % 2) : 1'b1;
      in_re      = W'(i);
      in_im      = -W'(i);
      fft_finish = (fin_rand && ($urandom % 2 == 1)) || (fin_last && i == N - 1);
      @(negedge clk);
      if (in_valid && in_ready) begin
        load_q.push_back({in_re, in_im});
        i++;
      end
      guard++;
    end
    chk("load_count", 64'(i), 64'(N));
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    fft_finish = 1'b0;
    @(negedge clk);
    chk("in_ready_after_load", 64'(in_ready), 64'(0));
    chk("busy_after_load", 64'(busy), 64'(1));
    // Finish pulses seen during LOAD (or with the last sample) must not start a drain.
    repeat (10) @(negedge clk);
    chk("no_early_drain", 64'(out_valid), 64'(0));
    chk("strobe_count", 64'(strobes), 64'(N));
    chk("load_q_empty", 64'(load_q.size()), 64'(0));
  endtask

  task automatic start_drain();
    logic [L-1:0] a;
    pops = 0;
    for (int k = 0; k < N; k++) begin
      a = brev(L'(k));
      out_q.push_back('{re: {{(W-L){1'b0}}, a}, im: ~{{(W-L){1'b0}}, a}, idx: L'(k),
                        last: (k == N - 1)});
    end
    @(posedge clk);
    #1 fft_finish = 1'b1;
    @(posedge clk);
    #1 fft_finish = 1'b0;
  endtask

  task automatic wait_idle(output int idle_cyc);
    int t = 0;
    idle_cyc = 0;
    while (t < 4000) begin
      @(negedge clk);
      if (!busy) break;
      t++;
    end
    chk("drain_timeout", 64'(t < 4000), 64'(1));
    idle_cyc = cyc;
  endtask

  initial begin
    int idle_cyc;
    #1 rst = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      in_valid   = 1'b1;
      in_re      = W'($urandom);
      in_im      = W'($urandom);
      fft_finish = 1'($urandom % 2);
    end
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_strobe", 64'(fft_initial_en), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_outputs", 64'({out_re, out_im, out_index, out_last}), 64'(0));
    chk("rst_core_ports", 64'({fft_datain_re, fft_datain_im, fft_read_addr}), 64'(0));
    in_valid   = 1'b0;
    fft_finish = 1'b0;
    rst        = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_no_strobe", 64'(strobes), 64'(0));
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));

    // Contiguous load with fft_finish on the last sample, then full-rate drain.
    rdy_rand = 1'b0;
    load_frame(1'b0, 1'b1, 1'b0);
    start_drain();
    wait_idle(idle_cyc);
    chk("full_rate_pops", 64'(pops), 64'(N));
    chk("full_rate_back_to_back", 64'(last_pop - first_pop), 64'(N - 1));
    chk("in_ready_after_last", 64'(idle_cyc), 64'(last_pop + 1));
    chk("idle_in_ready", 64'(in_ready), 64'(1));
    chk("out_q_empty_1", 64'(out_q.size()), 64'(0));

    // Gapped load with stray fft_finish pulses, then backpressured drain.
    load_frame(1'b1, 1'b0, 1'b1);
    rdy_rand = 1'b1;
    start_drain();
    wait_idle(idle_cyc);
    chk("bp_pops", 64'(pops), 64'(N));
    chk("out_q_empty_2", 64'(out_q.size()), 64'(0));

    // Reset in the middle of a drain.
    rdy_rand = 1'b0;
    load_frame(1'b0, 1'b0, 1'b0);
    start_drain();
    for (int t = 0; t < 1000 && pops < 100; t++) @(negedge clk);
    chk("mid_pops_reached", 64'(pops >= 100), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_outputs", 64'({out_re, out_im, out_index, out_last}), 64'(0));
    chk("mid_rst_state", 64'({busy, in_ready, fft_initial_en}), 64'(3'b010));
    chk("mid_rst_addr", 64'(fft_read_addr), 64'(0));
    out_q.delete();
    load_q.delete();
    @(negedge clk);
    rst = 1'b1;

    // Clean frame after the abort.
    load_frame(1'b0, 1'b0, 1'b0);
    start_drain();
    wait_idle(idle_cyc);
    chk("after_rst_pops", 64'(pops), 64'(N));
    chk("after_rst_back_to_back", 64'(last_pop - first_pop), 64'(N - 1));
    chk("out_q_empty_3", 64'(out_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Frame-level host sequencer for the in-place radix-2 FFT core. It accepts a valid/ready stream of complex samples and writes exactly N of them into the core's load port. It then waits for the core's `fft_finish`, sweeps the core's `read_addr` port over all N bins, and returns the results as a valid/ready output stream with full backpressure. It sits between the sample source and the FFT top and is the only driver of the core's load and read-out ports.

## Interface
- `N`, 512, points per frame (power of two)
- `L_max`, 9, log2(N); address width
- `W`, 24, signed width of each real/imag component
- `BITREV`, 0, 1 = output bin k is read from address bitrev(k); 0 = read from address k
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  input sample valid
- `in_ready`  out  1  input sample accepted when `in_valid`&`in_ready`
- `in_re`, `in_im`  in  W  signed input sample
- `fft_initial_en`  out  1  one-cycle strobe per sample; the core advances its load address on each strobe
- `fft_datain_re`, `fft_datain_im`  out  W  sample presented with the strobe
- `fft_finish`  in  1  core done; sampled only in WAIT
- `fft_read_addr`  out  L_max  read address to the core
- `fft_dataout_re`, `fft_dataout_im`  in  W  core read data, valid exactly 1 cycle after the address
- `out_valid`  out  1  result valid
- `out_ready`  in  1  result accepted when `out_valid`&`out_ready`
- `out_re`, `out_im`  out  W  result
- `out_index`  out  L_max  bin number k of the current result
- `out_last`  out  1  high with bin N-1
- `busy`  out  1  state ≠ IDLE

## Operation
- States: IDLE, LOAD, WAIT, DRAIN.
- IDLE: `in_ready`=1. The first accepted sample moves to LOAD with load count = 1.
- LOAD: `in_ready`=1 until count = N. Each accepted sample increments the count. On acceptance number N, go to WAIT.
- Every accepted sample is registered onto `fft_datain_*`, and `fft_initial_en` pulses in the following cycle. Gaps in `in_valid` produce gaps in the strobe; samples are never dropped or reordered.
- WAIT: `in_ready`=0. `fft_finish`=1 in any cycle moves to DRAIN. `fft_finish` is ignored in IDLE, LOAD and DRAIN, whether it is a level or a pulse.
- DRAIN:
  - Issue counter `ia` runs 0..N-1. `fft_read_addr` = `BITREV` ? bitrev(`ia`) : `ia`.
  - Returned data enters a 2-entry output FIFO tagged with its index.
  - Issue rule: issue when fifo_count + inflight − pop < 2, where pop = `out_valid`&`out_ready`. This gives 1 result per cycle when `out_ready` is held high.
  - After N issues, stop issuing and hold `fft_read_addr` at the last value.
  - Acceptance of bin N-1 (`out_last`) returns to IDLE.
- Output FIFO head drives `out_*`. Data and tag are held stable while `out_valid`&!`out_ready`.
- Arithmetic: no arithmetic on sample data; data passes through bit-exact. The counters are L_max+1 bits so the value N is representable.

## Timing
- Reset (`rst`=0, asynchronous):
  - state IDLE, all counters 0, FIFO empty
  - `fft_initial_en`=0, `fft_datain_*`=0, `fft_read_addr`=0
  - `out_valid`=0, `out_re`/`out_im`/`out_index`=0, `out_last`=0, `busy`=0
  - `in_ready` = 1 (IDLE decode)
- Reset asserted mid-frame aborts the frame immediately with no further strobes.
- `in_ready`, `busy` and `out_valid` are decoded from registered state/FIFO only. No combinational path runs from `in_valid` or `out_ready` to `in_ready`.
- Load: handshake at edge t gives `fft_initial_en`=1 during cycle t+1.
- Drain: first address in the first DRAIN cycle; its data arrives 1 cycle later; earliest `out_valid` is 2 cycles after the WAIT→DRAIN edge.
- `fft_finish` arriving in the same cycle as the Nth input acceptance is ignored; WAIT needs a later `fft_finish`.
- Input presented during WAIT/DRAIN stalls (`in_ready`=0) until IDLE. `in_ready` rises the cycle after `out_last` is accepted.

## Test plan
- Reset sanity: hold `rst`=0 with random inputs -> all outputs at reset values and `in_ready`=1 after release; no strobe.
- Contiguous load, N=512: 512 samples (re=i, im=−i) with `in_valid`=1 -> 512 consecutive `fft_initial_en` pulses carrying i/−i in order, `in_ready`=0 from the cycle after sample 511, `busy`=1.
- Gapped load: `in_valid` random 50% -> strobe count exactly 512, data order preserved; `fft_finish` pulsed during LOAD has no effect.
- Full-rate drain: model core returning re=addr, im=~addr; `fft_finish` pulse; `out_ready`=1 -> 512 results in 512 consecutive cycles, `out_index`=0..511, `out_last` only on 511, return to IDLE.
- Backpressure drain with `BITREV`=1: random `out_ready` -> for every k, `out_re`=bitrev9(k); no loss or duplication; outputs stable while stalled; `fft_read_addr` never exceeds 2 ahead of acceptance.
- Mid-drain reset: assert `rst` after 100 results -> outputs at reset values immediately; a following full frame runs correctly from IDLE.
